// File: rtl/mp_add_seq.sv
// mp_add_seq: sequences WORDS x 16-bit add/subtract through an external 16-bit adder, LSW first
module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [16*WORDS-1:0]   op_a,
  input  logic [16*WORDS-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   result,
  output logic                  cout,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [15:0]           add_s,
  input  logic                  add_cout
);
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [16*WORDS-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic                sub_q, sub_d, carry_q, carry_d, cout_q, cout_d;
  logic                run, accept, last;
  assign run     = state_q == RUN;
  assign accept  = start && !run;
  assign last    = idx_q == IW'(WORDS - 1);
  assign busy    = run;
  assign done    = state_q == DONE;
  assign result  = result_q;
  assign cout    = cout_q;
  assign add_a   = run ? a_q[16*idx_q +: 16] : 16'd0;
  assign add_b   = run ? (sub_q ? ~b_q[16*idx_q +: 16] : b_q[16*idx_q +: 16]) : 16'd0;
  assign add_cin = run & carry_q;
  // Next state: latch a new operation when not busy, otherwise capture one slice per RUN cycle
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    if (accept) begin
      state_d  = RUN;
      idx_d    = '0;
      a_d      = op_a;
      b_d      = op_b;
      sub_d    = sub;
      carry_d  = sub | cin;
      result_d = '0;
    end else if (run) begin
      result_d[16*idx_q +: 16] = add_s;
      carry_d = add_cout;
      idx_d   = last ? '0 : idx_q + IW'(1);
      cout_d  = last ? add_cout : cout_q;
      state_d = last ? DONE : RUN;
    end else if (done) begin
      state_d = IDLE;
    end
  end
  // State and datapath registers, cleared asynchronously so a reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end
endmodule
